data_cache: RTL



---
 rtl/data_cache_pkg.sv | 29 ++
 rtl/data_cache_line_array.sv | 54 +++++
 rtl/data_cache.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/data_cache_pkg.sv
// Shared types and width helpers for the direct-mapped write-through data cache.
package data_cache_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_WRITE
    } state_t;

    localparam int CNT_W = 16;

    function automatic int offset_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int word_size, input int line_words, input int num_lines);
        return word_size - $clog2(line_words) - $clog2(num_lines);
    endfunction

    // Clears the word-offset bits so the fill request names the first word of the line.
    function automatic logic [31:0] line_base(input logic [31:0] addr, input int off_bits);
        return addr & ~((32'd1 << off_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/data_cache_line_array.sv
// Valid/tag/data storage: combinational lookup, synchronous line install and word update.
module cache_line_array
    import data_cache_pkg::*;
#(
    parameter int WORD_SIZE  = 16,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 4,
    localparam int OFF_W = offset_w(LINE_WORDS),
    localparam int IDX_W = index_w(NUM_LINES),
    localparam int TAG_W = tag_w(WORD_SIZE, LINE_WORDS, NUM_LINES)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [IDX_W-1:0]                 rd_index,
    input  logic [OFF_W-1:0]                 rd_offset,
    output logic                             rd_valid,
    output logic [TAG_W-1:0]                 rd_tag,
    output logic [WORD_SIZE-1:0]             rd_word,
    input  logic                             fill_en,
    input  logic [IDX_W-1:0]                 fill_index,
    input  logic [TAG_W-1:0]                 fill_tag,
    input  logic [LINE_WORDS*WORD_SIZE-1:0]  fill_line,
    input  logic                             upd_en,
    input  logic [IDX_W-1:0]                 upd_index,
    input  logic [OFF_W-1:0]                 upd_offset,
    input  logic [WORD_SIZE-1:0]             upd_word
);

    logic [NUM_LINES-1:0]                  valid;
    logic [TAG_W-1:0]                      tags  [NUM_LINES];
    logic [LINE_WORDS-1:0][WORD_SIZE-1:0]  lines [NUM_LINES];

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_word  = lines[rd_index][rd_offset];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            valid <= '0;
        else if (fill_en)
            valid[fill_index] <= 1'b1;
    end

    // Tags and data carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tags[fill_index]  <= fill_tag;
            lines[fill_index] <= fill_line;
        end else if (upd_en) begin
            lines[upd_index][upd_offset] <= upd_word;
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with line fills over req/ack.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int WORD_SIZE  = 16,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             d_readM,
    input  logic                             d_writeM,
    input  logic [WORD_SIZE-1:0]             d_address,
    inout  wire  [WORD_SIZE-1:0]             d_data,
    output logic                             d_stall,
    output logic                             m_read,
    output logic                             m_write,
    output logic [WORD_SIZE-1:0]             m_address,
    output logic [WORD_SIZE-1:0]             m_wdata,
    input  logic [LINE_WORDS*WORD_SIZE-1:0]  m_rdata,
    input  logic                             m_ack,
    output logic [CNT_W-1:0]                 read_hits,
    output logic [CNT_W-1:0]                 read_misses
);

    localparam int OFF_W = offset_w(LINE_WORDS);
    localparam int IDX_W = index_w(NUM_LINES);
    localparam int TAG_W = tag_w(WORD_SIZE, LINE_WORDS, NUM_LINES);

    state_t state, state_n;

    logic                 rd_valid, hit, req, drive;
    logic [TAG_W-1:0]     rd_tag;
    logic [WORD_SIZE-1:0] rd_word;
    logic                 start_fill, start_write, fill_en, upd_en, write_done;
    logic                 cnt_hit, cnt_miss, wr_hit;

    assign req = d_readM | d_writeM;
    assign hit = rd_valid && (rd_tag == d_address[WORD_SIZE-1 -: TAG_W]);

    assign d_data = drive ? rd_word : {WORD_SIZE{1'bz}};

    // m_address doubles as the latched request address for install and update.
    cache_line_array #(
        .WORD_SIZE (WORD_SIZE),
        .LINE_WORDS(LINE_WORDS),
        .NUM_LINES (NUM_LINES)
    ) u_array (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_index  (d_address[OFF_W +: IDX_W]),
        .rd_offset (d_address[OFF_W-1:0]),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_word   (rd_word),
        .fill_en   (fill_en),
        .fill_index(m_address[OFF_W +: IDX_W]),
        .fill_tag  (m_address[WORD_SIZE-1 -: TAG_W]),
        .fill_line (m_rdata),
        .upd_en    (upd_en),
        .upd_index (m_address[OFF_W +: IDX_W]),
        .upd_offset(m_address[OFF_W-1:0]),
        .upd_word  (m_wdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n     = state;
        d_stall     = 1'b0;
        drive       = 1'b0;
        cnt_hit     = 1'b0;
        cnt_miss    = 1'b0;
        start_fill  = 1'b0;
        start_write = 1'b0;
        fill_en     = 1'b0;
        upd_en      = 1'b0;
        write_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (d_writeM) begin
                    d_stall     = 1'b1;
                    start_write = 1'b1;
                    state_n     = S_WRITE;
                end else if (d_readM) begin
                    if (hit) begin
                        drive   = 1'b1;
                        cnt_hit = 1'b1;
                    end else begin
                        d_stall    = 1'b1;
                        cnt_miss   = 1'b1;
                        start_fill = 1'b1;
                        state_n    = S_FILL;
                    end
                end
            end
            S_FILL: begin
                // The retried read completes next cycle, so the ack cycle still stalls.
                d_stall = req;
                if (m_ack) begin
                    fill_en = 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_WRITE: begin
                d_stall = req & ~m_ack;
                if (m_ack) begin
                    write_done = 1'b1;
                    upd_en     = wr_hit;
                    state_n    = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_read      <= 1'b0;
            m_write     <= 1'b0;
            m_address   <= '0;
            m_wdata     <= '0;
            wr_hit      <= 1'b0;
            read_hits   <= '0;
            read_misses <= '0;
        end else begin
            if (start_fill) begin
                m_read    <= 1'b1;
                m_address <= WORD_SIZE'(line_base(32'(d_address), OFF_W));
            end
            // No fill can run during a write, so the hit seen at issue is still valid at ack.
            if (start_write) begin
                m_write   <= 1'b1;
                m_address <= d_address;
                m_wdata   <= d_data;
                wr_hit    <= hit;
            end
            if (fill_en)
                m_read <= 1'b0;
            if (write_done)
                m_write <= 1'b0;
            if (cnt_hit && read_hits != '1)
                read_hits <= read_hits + 1'b1;
            if (cnt_miss && read_misses != '1)
                read_misses <= read_misses + 1'b1;
        end
    end

endmodule
